clc_key: RTL and testbench

Sequential modular-exponentiation engine that computes the shared Diffie-Hellman secret K = r^x mod p. It takes the peer's public value r and the local private exponent x, and it is the consuming end of the public-value exchange whose producer generates R = g^y mod p. It uses right-to-left square-and-multiply over an interleaved shift-add modular multiplier, one multiplier bit per clock. It sits after the public-value receive path and feeds the key register bank.

---
 rtl/clc_key.sv | 173 +++++++++++++++++
 tb/tb_clc_key.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/clc_key.sv
// clc_key: shared-secret engine K = r^x mod p.
// Right-to-left square-and-multiply built on a bit-serial interleaved
// shift-add modular multiplier that consumes one multiplier bit per clock.
module clc_key #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] key,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, RED, CHK, MULR, MULB, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, p_q, p_d, e_q, e_d;
  logic [WIDTH-1:0] res_q, res_d, base_q, base_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             err_q, err_d, done_q, done_d, busy_q, busy_d;

  // Multiplier datapath: operand selection and one reduction step
  logic [WIDTH-1:0] mm_a, mm_b, mm_res;
  logic [WIDTH+1:0] t, pw;
  logic             a_bit, mm_last;

  // Pick multiplier operands for the active state and compute one step
  always_comb begin
    mm_a = r_q;
    mm_b = WIDTH'(1);
    case (state_q)
      MULR:    begin mm_a = res_q;  mm_b = base_q; end
      MULB:    begin mm_a = base_q; mm_b = base_q; end
      default: begin mm_a = r_q;    mm_b = WIDTH'(1); end
    endcase
    a_bit   = mm_a[CW'(WIDTH-1) - cnt_q];
    mm_last = (cnt_q == CW'(WIDTH-1));
    pw      = {2'b00, p_q};
    t       = {acc_q, 1'b0};
    if (t >= pw) t = t - pw;
    if (a_bit)   t = t + {2'b00, mm_b};
    if (t >= pw) t = t - pw;
    mm_res  = t[WIDTH-1:0];
  end

  // Sequencer: next state, operand updates and result capture
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    p_d     = p_q;
    e_d     = e_q;
    res_d   = res_q;
    base_d  = base_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    err_d   = err_q;
    done_d  = 1'b0;

    // Shared multiplier stepping for RED/MULR/MULB; acc and cnt rearm on the last bit
    if (state_q == RED || state_q == MULR || state_q == MULB) begin
      acc_d = t[WIDTH:0];
      cnt_d = cnt_q + 1'b1;
      if (mm_last) begin
        acc_d = '0;
        cnt_d = '0;
      end
    end

    case (state_q)
      IDLE: begin
        if (st) begin
          r_d     = r;
          p_d     = p;
          e_d     = x;
          res_d   = WIDTH'(1);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RED;
        end
      end
      RED: begin
        // Invalid modulus is caught on the first RED cycle, so no arithmetic runs
        if (p_q < WIDTH'(2)) begin
          acc_d   = '0;
          cnt_d   = '0;
          key_d   = '0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (mm_last) begin
          base_d  = mm_res;
          state_d = CHK;
        end
      end
      CHK: begin
        if (e_q == '0) begin
          key_d   = res_q;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (e_q[0]) begin
          state_d = MULR;
        end else begin
          state_d = MULB;
        end
      end
      MULR: begin
        if (mm_last) begin
          res_d   = mm_res;
          state_d = MULB;
        end
      end
      MULB: begin
        if (mm_last) begin
          base_d  = mm_res;
          e_d     = e_q >> 1;
          state_d = CHK;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  // State and datapath registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      p_q     <= '0;
      e_q     <= '0;
      res_q   <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      p_q     <= p_d;
      e_q     <= e_d;
      res_q   <= res_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign key  = key_q;
  assign err  = err_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_clc_key.sv
// tb_clc_key: table vectors, random triples against a pow() model, reset abort.
module tb_clc_key;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, st;
  logic [W-1:0] r, x, p, key;
  logic         busy, done, err;

  always #5 clk = ~clk;

  clc_key #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .st(st), .r(r), .x(x), .p(p),
    .key(key), .busy(busy), .done(done), .err(err)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] r, x, p, key;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_pow(input logic [31:0] b0, input logic [31:0] e0, input logic [31:0] m0);
    longint unsigned b, res, m;
    m   = 64'(m0);
    b   = 64'(b0) % m;
    res = 1 % m;
    for (int i = 0; i < 32; i++) begin
      if (e0[i]) res = (res * b) % m;
      b = (b * b) % m;
    end
    return res[31:0];
  endfunction

  function automatic int ref_lat(input logic [31:0] e0, input logic [31:0] m0);
    int n, k;
    if (m0 < 2) return 1;
    n = 0; k = 0;
    for (int i = 0; i < 32; i++) if (e0[i]) begin n = i + 1; k++; end
    return W * (1 + n + k) + n + 1;
  endfunction

  task automatic run_op(input logic [31:0] ir, input logic [31:0] ix, input logic [31:0] ip,
                        input bit toggle, output logic [31:0] k, output logic e,
                        output int lat, output bit busy_ok, output bit pulse_ok);
    k = '0; e = 1'b0; lat = -1; busy_ok = 1; pulse_ok = 0;
    @(negedge clk);
    r = ir; x = ix; p = ip; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      if (toggle) begin
        r = $urandom; x = $urandom; p = $urandom; st = 1'($urandom);
      end
      @(posedge clk); #1;
      if (done) begin
        st = 1'b0;
        lat = c; k = key; e = err;
        if (busy) busy_ok = 0;
        break;
      end
      if (!busy) busy_ok = 0;
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
      pulse_ok = !done && !busy;
    end
  endtask

  task automatic do_vec(input string nm, input logic [31:0] ir, input logic [31:0] ix,
                        input logic [31:0] ip, input bit toggle, input logic [31:0] ek,
                        input logic ee, input int el);
    logic [31:0] k; logic e; int lat; bit bok, pok;
    run_op(ir, ix, ip, toggle, k, e, lat, bok, pok);
    chk({nm, ".latency"}, 64'(lat), 64'(el));
    chk({nm, ".key"}, 64'(k), 64'(ek));
    chk({nm, ".err"}, 64'(e), 64'(ee));
    chk({nm, ".busy"}, 64'(bok), 64'd1);
    chk({nm, ".pulse"}, 64'(pok), 64'd1);
  endtask

  initial begin
    logic [31:0] rr, xx, pp;
    tbl[0] = '{r: 19,  x: 6,  p: 23, key: 2,  err: 0, lat: 196};
    tbl[1] = '{r: 8,   x: 15, p: 23, key: 2,  err: 0, lat: 293};
    tbl[2] = '{r: 100, x: 1,  p: 23, key: 8,  err: 0, lat: 98};
    tbl[3] = '{r: 7,   x: 0,  p: 23, key: 1,  err: 0, lat: 33};
    tbl[4] = '{r: 5,   x: 3,  p: 1,  key: 0,  err: 1, lat: 1};
    tbl[5] = '{r: 5,   x: 3,  p: 0,  key: 0,  err: 1, lat: 1};
    tbl[6] = '{r: 5,   x: 3,  p: 23, key: 10, err: 0, lat: 163};
    tbl[7] = '{r: 32'hFFFF_FFFF, x: 32'hFFFF_FFFF, p: 32'hFFFF_FFFB,
               key: 1024, err: 0, lat: 2113};

    rst = 1'b0; st = 1'b0; r = '0; x = '0; p = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.key", 64'(key), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++)
      do_vec($sformatf("tbl%0d", i), tbl[i].r, tbl[i].x, tbl[i].p, 1'b0,
             tbl[i].key, tbl[i].err, tbl[i].lat);

    // Inputs and st wiggled while busy must not disturb the result
    do_vec("toggle", 19, 6, 23, 1'b1, 2, 1'b0, 196);

    // Reset asserted in the middle of MULR (x=6: MULR spans edges 67..98)
    @(negedge clk);
    r = 19; x = 6; p = 23; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    repeat (80) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("abort.key", 64'(key), 64'd0);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.err", 64'(err), 64'd0);
    begin
      bit saw_done = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (done) saw_done = 1;
      end
      chk("abort.nodone", 64'(saw_done), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    do_vec("after_reset", 19, 6, 23, 1'b0, 2, 1'b0, 196);

    // Random triples against the arithmetic model; short exponents bound runtime
    for (int i = 0; i < 100; i++) begin
      rr = $urandom;
      xx = $urandom & ((32'h1 << $urandom_range(0, 7)) - 1);
      pp = (i % 2 == 0) ? $urandom : 32'($urandom_range(2, 1000));
      if (pp < 2) pp = pp + 2;
      do_vec($sformatf("rnd%0d", i), rr, xx, pp, 1'(i % 3 == 0),
             ref_pow(rr, xx, pp), 1'b0, ref_lat(xx, pp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
